matrix_operand_sequencer: RTL
=============================

Name: matrix_operand_sequencer

Overview:
- Upstream feeder for matrix_mac_unit.
- Holds two DIM x DIM operand matrices A and B, loaded through a simple write port.
- On start, streams every A[i][k] / B[k][j] pair into the MAC as matrix_1 / matrix_2, driving its enable and clear so that each DIM-long dot product accumulates C[i][j].
- Flags, with row/col indices, the cycle in which the MAC result is valid for downstream capture.

Parameters:
- DATA_WIDTH, 8, operand width; matches the MAC unit.
- DIM, 4, matrix dimension (square); legal range 2..16.
- MAC_LATENCY, 1, cycles from the last operand of a dot product to a valid MAC result.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  operand write strobe; honoured only when busy=0.
- wr_sel  in  1  0 = matrix A, 1 = matrix B.
- wr_addr  in  $clog2(DIM*DIM)  row-major index (row*DIM+col).
- wr_data  in  DATA_WIDTH  operand value.
- start  in  1  begin a multiply; honoured only when busy=0.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse when the final result is valid.
- mac_enable  out  1  MAC enable.
- mac_clear  out  1  MAC clear (accumulator := product).
- matrix_1  out  DATA_WIDTH  A operand.
- matrix_2  out  DATA_WIDTH  B operand.
- result_valid  out  1  MAC result equals C[out_row][out_col] this cycle.
- out_row  out  $clog2(DIM)  row index of the valid result.
- out_col  out  $clog2(DIM)  column index of the valid result.

Behaviour:
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on start.
  - RUN -> FLUSH after the last operand pair.
  - FLUSH -> IDLE after MAC_LATENCY cycles.
- Reset: state IDLE; counters i/j/k at 0; every output 0; latency pipe cleared. Operand storage is not reset; its contents are retained through reset and undefined after power-up.
- Writes: accepted in IDLE only; commit at the clock edge; ignored while busy. A write and a start in the same cycle: the write is committed and is visible to the run.
- RUN issue order: k fastest, then j, then i.
  - One pair is issued per cycle; all MAC-facing outputs are registered.
  - Each RUN cycle drives mac_enable=1, matrix_1=A[i][k], matrix_2=B[k][j], and mac_clear=1 exactly when k==0.
- Counter wrap: k wraps DIM-1 -> 0 and increments j; j wraps and increments i. The issue of i=j=k=DIM-1 is the last RUN cycle.
- Timing:
  - Start sampled at cycle 0.
  - First pair issued at cycle 1.
  - Last pair issued at cycle DIM^3.
  - Outside RUN: mac_enable=0, mac_clear=0, matrix_1/matrix_2 hold 0.
- result_valid: asserted MAC_LATENCY cycles after each cycle issuing k==DIM-1, carrying that (i,j). A MAC_LATENCY-deep shift pipe carries valid, row and col. DIM^2 result_valid pulses occur per run.
- done: coincides with the final result_valid, at cycle DIM^3+MAC_LATENCY. busy falls the cycle after done.
- start while busy: ignored, with no queueing.
- reset mid-run: run aborted; no further result_valid or done; next cycle is IDLE with all outputs 0.
- Arithmetic: none. The block is pure sequencing; widths pass through unchanged.

Optional Feature:
- Macro: MATRIX_SEQ_STALL_EN.
- When defined:
  - Adds input port stall (1 bit).
  - While stall=1 in RUN or FLUSH: counters, FSM and the latency pipe freeze, and mac_enable=0 and result_valid=0 for that cycle.
  - Operands and indices hold their values; sequencing resumes unchanged when stall deasserts.
  - stall is ignored in IDLE.
- When undefined: no stall port; timing is exactly as above.

Decomposition:
- Shared package matrix_mac_pkg holds:
  - the default DATA_WIDTH constant;
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2);
  - the wr_sel encodings.
- One sub-module, matrix_operand_bank: a DIM*DIM x DATA_WIDTH register file with one synchronous write port and two combinational read ports. It is instantiated twice, once for A and once for B.

Test Plan:
- DIM=2, MAC_LATENCY=1, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> pairs (1,5)c,(2,7),(1,6)c,(2,8),(3,5)c,(4,7),(3,6)c,(4,8) on cycles 1..8; with a behavioural MAC, results 19,22,43,50 valid on cycles 3,5,7,9 with (row,col) (0,0),(0,1),(1,0),(1,1); done at cycle 9.
- DIM=4, identity A, B[r][c]=r*4+c -> the 16 results equal B in row-major order; done at cycle 65; busy high for cycles 1..65.
- Write A[0][0]=9 in the same cycle as start -> first pair issued is (9, B[0][0]).
- start pulsed at cycles 3 and 20 during a run, plus a wr_en to A -> both ignored; a second run after done shows the old A data.
- Reset asserted at cycle 5 of a DIM=2 run -> cycle 6: all outputs 0, busy=0; no done; a new start then gives the full correct sequence.
- MATRIX_SEQ_STALL_EN defined, stall high for cycles 3..5 of the first test -> issue sequence unchanged but delayed 3 cycles; done at cycle 12; no result_valid during stall.

Source files
------------

// File: rtl/matrix_mac_pkg.sv
// Shared constants and encodings for the matrix MAC datapath.
package matrix_mac_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } seq_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/matrix_operand_bank.sv
// DIM*DIM operand register file: one sync write port, two comb read ports.
module matrix_operand_bank
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DIM        = 4
) (
  input  logic                       clock,
  input  logic                       wr_en,
  input  logic [$clog2(DIM*DIM)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [$clog2(DIM*DIM)-1:0] rd_addr_0,
  output logic [DATA_WIDTH-1:0]      rd_data_0,
  input  logic [$clog2(DIM*DIM)-1:0] rd_addr_1,
  output logic [DATA_WIDTH-1:0]      rd_data_1
);

  logic [DATA_WIDTH-1:0] mem [DIM*DIM];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_0 = mem[rd_addr_0];
  assign rd_data_1 = mem[rd_addr_1];

endmodule

// File: rtl/matrix_operand_sequencer.sv
// Streams A[i][k]/B[k][j] pairs into the MAC, k fastest, then j, then i.
// Define MATRIX_SEQ_STALL_EN to add a stall input that freezes a run.
module matrix_operand_sequencer
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DIM         = 4,
  parameter int MAC_LATENCY = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [$clog2(DIM*DIM)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       start,
`ifdef MATRIX_SEQ_STALL_EN
  input  logic                       stall,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       mac_enable,
  output logic                       mac_clear,
  output logic [DATA_WIDTH-1:0]      matrix_1,
  output logic [DATA_WIDTH-1:0]      matrix_2,
  output logic                       result_valid,
  output logic [$clog2(DIM)-1:0]     out_row,
  output logic [$clog2(DIM)-1:0]     out_col
);

  localparam int AW = $clog2(DIM*DIM);
  localparam int IW = $clog2(DIM);
  localparam logic [IW-1:0] LAST = IW'(DIM-1);

  typedef struct packed {
    logic          v;
    logic          last;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
  } tag_t;

  seq_state_t state_q, state_d;
  logic [IW-1:0] i_q, j_q, k_q;
  logic [IW-1:0] i_d, j_d, k_d;
  logic issue, last_pair, stall_act;
  logic en_q, clr_q;
  logic [DATA_WIDTH-1:0] m1_q, m2_q;
  logic [AW-1:0] a_addr, b_addr;
  logic [DATA_WIDTH-1:0] a_rd, b_rd, a_op, b_op;
  logic [DATA_WIDTH-1:0] unused_rd_a, unused_rd_b;
  logic a_we, b_we;
  tag_t pipe_q [MAC_LATENCY];
  tag_t tag_in, tag_out;

`ifdef MATRIX_SEQ_STALL_EN
  assign stall_act = stall && (state_q != IDLE);
`else
  assign stall_act = 1'b0;
`endif

  assign a_we = wr_en && (state_q == IDLE) && (wr_sel == SEL_A);
  assign b_we = wr_en && (state_q == IDLE) && (wr_sel == SEL_B);

  assign last_pair = (i_q == LAST) && (j_q == LAST) && (k_q == LAST);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          issue   = 1'b1;
        end
      end
      RUN: begin
        if (last_pair) begin
          state_d = FLUSH;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end else begin
          issue = 1'b1;
          if (k_q == LAST) begin
            k_d = '0;
            if (j_q == LAST) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + IW'(1);
            end
          end else begin
            k_d = k_q + IW'(1);
          end
        end
      end
      FLUSH: begin
        if (tag_out.v && tag_out.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a_addr = AW'(i_d) * AW'(DIM) + AW'(k_d);
  assign b_addr = AW'(k_d) * AW'(DIM) + AW'(j_d);

  matrix_operand_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DIM       (DIM)
  ) u_bank_a (
    .clock    (clock),
    .wr_en    (a_we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr_0(a_addr),
    .rd_data_0(a_rd),
    .rd_addr_1(wr_addr),
    .rd_data_1(unused_rd_a)
  );

  matrix_operand_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DIM       (DIM)
  ) u_bank_b (
    .clock    (clock),
    .wr_en    (b_we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr_0(b_addr),
    .rd_data_0(b_rd),
    .rd_addr_1(wr_addr),
    .rd_data_1(unused_rd_b)
  );

  // a write landing with start must reach the first issued pair
  assign a_op = (a_we && wr_addr == a_addr) ? wr_data : a_rd;
  assign b_op = (b_we && wr_addr == b_addr) ? wr_data : b_rd;

  always_comb begin
    tag_in = '0;
    if (en_q && k_q == LAST) begin
      tag_in.v    = 1'b1;
      tag_in.last = last_pair;
      tag_in.row  = i_q;
      tag_in.col  = j_q;
    end
  end

  assign tag_out = pipe_q[MAC_LATENCY-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      m1_q    <= '0;
      m2_q    <= '0;
      for (int n = 0; n < MAC_LATENCY; n++) begin
        pipe_q[n] <= '0;
      end
    end else if (!stall_act) begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      en_q    <= issue;
      clr_q   <= issue && (k_d == '0);
      m1_q    <= issue ? a_op : '0;
      m2_q    <= issue ? b_op : '0;
      pipe_q[0] <= tag_in;
      for (int n = 1; n < MAC_LATENCY; n++) begin
        pipe_q[n] <= pipe_q[n-1];
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign mac_enable   = en_q && !stall_act;
  assign mac_clear    = clr_q;
  assign matrix_1     = m1_q;
  assign matrix_2     = m2_q;
  assign result_valid = tag_out.v && !stall_act;
  assign done         = tag_out.v && tag_out.last && !stall_act;
  assign out_row      = tag_out.row;
  assign out_col      = tag_out.col;

endmodule
